// File: rtl/mem_arbiter_pkg.sv
// Shared types for mem_arbiter: FSM states, requester ids and the latched request.
package mem_arbiter_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DATA
    } state_t;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_t;

    typedef struct packed {
        addr_t      addr;
        data_t      wdata;
        logic [3:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the core/debug request-response ports and the memory_map port.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic       core_req_valid;
    logic       core_req_ready;
    addr_t      core_addr;
    data_t      core_wdata;
    logic [3:0] core_wstrb;
    logic       core_rsp_valid;
    data_t      core_rdata;

    logic       dbg_req_valid;
    logic       dbg_req_ready;
    addr_t      dbg_addr;
    data_t      dbg_wdata;
    logic [3:0] dbg_wstrb;
    logic       dbg_rsp_valid;
    data_t      dbg_rdata;

    addr_t      mem_address;
    data_t      mem_write_data;
    logic [3:0] mem_write_enable;
    data_t      mem_read_data;

    modport slave (
        input  core_req_valid, core_addr, core_wdata, core_wstrb,
        output core_req_ready, core_rsp_valid, core_rdata,
        input  dbg_req_valid, dbg_addr, dbg_wdata, dbg_wstrb,
        output dbg_req_ready, dbg_rsp_valid, dbg_rdata,
        output mem_address, mem_write_data, mem_write_enable,
        input  mem_read_data
    );

    modport master (
        output core_req_valid, core_addr, core_wdata, core_wstrb,
        input  core_req_ready, core_rsp_valid, core_rdata,
        output dbg_req_valid, dbg_addr, dbg_wdata, dbg_wstrb,
        input  dbg_req_ready, dbg_rsp_valid, dbg_rdata,
        input  mem_address, mem_write_data, mem_write_enable,
        output mem_read_data
    );

endinterface

// File: rtl/mem_arbiter_grant.sv
// Grant logic for the two requesters (bit 0 core, bit 1 debug).
// MEM_ARBITER_ROUND_ROBIN_EN selects round-robin with a last-grant register; default is fixed priority.
module mem_arbiter_grant
    import mem_arbiter_pkg::*;
(
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    input  logic       clk,
    input  logic       reset,
`endif
    input  logic       slot,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    req_id_t last_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= REQ_DBG;
        else if (|grant)
            last_grant <= grant[1] ? REQ_DBG : REQ_CORE;
    end

    // On contention hand the slot to whoever was not served last
    always_comb begin
        grant = 2'b00;
        if (slot) begin
            if (valid == 2'b11)
                grant = (last_grant == REQ_CORE) ? 2'b10 : 2'b01;
            else
                grant = valid;
        end
    end
`else
    always_comb begin
        grant = 2'b00;
        if (slot) begin
            if (valid[0])
                grant = 2'b01;
            else if (valid[1])
                grant = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory_map port between core and debug, one access at a time,
// with a fixed accept->response latency of 2. MEM_ARBITER_ROUND_ROBIN_EN enables round-robin grant.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int REQ_N = 2
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    state_t           state, state_nxt;
    mem_req_t         req_q, req_in;
    req_id_t          owner;
    logic [REQ_N-1:0] valid, grant;
    logic             slot, accept;
    logic [3:0]       we;
    logic             core_rsp, dbg_rsp;
    data_t            rdata;

    assign valid = {bus.dbg_req_valid, bus.core_req_valid};
    // Reset is folded in so no ready can leak out while the FSM is held
    assign slot  = !reset && (state == ST_IDLE || state == ST_DATA);

    mem_arbiter_grant u_grant (
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        .clk   (clk),
        .reset (reset),
`endif
        .slot  (slot),
        .valid (valid),
        .grant (grant)
    );

    assign accept             = |grant;
    assign bus.core_req_ready = grant[0];
    assign bus.dbg_req_ready  = grant[1];

    always_comb begin
        if (grant[1])
            req_in = '{addr: bus.dbg_addr, wdata: bus.dbg_wdata, wstrb: bus.dbg_wstrb};
        else
            req_in = '{addr: bus.core_addr, wdata: bus.core_wdata, wstrb: bus.core_wstrb};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            req_q <= '0;
            owner <= REQ_CORE;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_q <= req_in;
                owner <= grant[1] ? REQ_DBG : REQ_CORE;
            end
        end
    end

    // DATA keeps the address stable so the registered read lands on the right word
    always_comb begin
        state_nxt = state;
        we        = 4'h0;
        core_rsp  = 1'b0;
        dbg_rsp   = 1'b0;
        rdata     = '0;
        case (state)
            ST_IDLE: begin
                if (accept)
                    state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                state_nxt = ST_DATA;
                we        = req_q.wstrb;
            end
            ST_DATA: begin
                state_nxt = accept ? ST_ACCESS : ST_IDLE;
                core_rsp  = (owner == REQ_CORE);
                dbg_rsp   = (owner == REQ_DBG);
                rdata     = (req_q.wstrb == 4'h0) ? bus.mem_read_data : '0;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.mem_address      = req_q.addr;
    assign bus.mem_write_data   = req_q.wdata;
    assign bus.mem_write_enable = we;
    assign bus.core_rsp_valid   = core_rsp;
    assign bus.dbg_rsp_valid    = dbg_rsp;
    assign bus.core_rdata       = core_rsp ? rdata : '0;
    assign bus.dbg_rdata        = dbg_rsp  ? rdata : '0;

endmodule
